hi_lo_muldiv: RTL



---
 rtl/hi_lo_muldiv.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/hi_lo_muldiv.sv
// Multi-cycle signed multiply/divide unit owning the HI/LO registers.
// Radix-2 Booth multiply and restoring divide, 32 iterations each.
module hi_lo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] accHi_q, accHi_d;
  logic [31:0] accLo_q, accLo_d;
  logic        accQm1_q, accQm1_d;
  logic [31:0] operand_q, operand_d;
  logic        negQuot_q, negQuot_d;
  logic        negRem_q, negRem_d;
  logic        divZero_q, divZero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        lastIter;
  logic [31:0] absA, absB;
  logic [32:0] boothHi, boothOp, boothSum;
  logic [31:0] multHi, multLo;
  logic        multQm1;
  logic [32:0] divShifted, divTrial;
  logic        divFits;
  logic [31:0] divRem, divQuot;
  logic [31:0] remSigned, quotSigned;

  assign lastIter = (count_q == 6'd31);
  assign absA     = A[31] ? -A : A;
  assign absB     = B[31] ? -B : B;

  // Booth step: 33-bit sign-extended add/sub keeps 0x80000000 operands exact.
  always_comb begin
    boothHi = {accHi_q[31], accHi_q};
    boothOp = {operand_q[31], operand_q};
    case ({accLo_q[0], accQm1_q})
      2'b01:   boothSum = boothHi + boothOp;
      2'b10:   boothSum = boothHi - boothOp;
      default: boothSum = boothHi;
    endcase
    multHi  = boothSum[32:1];
    multLo  = {boothSum[0], accLo_q[31:1]};
    multQm1 = accLo_q[0];
  end

  // Restoring step: accHi holds the partial remainder, accLo shifts the
  // dividend out and the quotient bits in.
  always_comb begin
    divShifted = {accHi_q, accLo_q[31]};
    divTrial   = divShifted - {1'b0, operand_q};
    divFits    = ~divTrial[32];
    divRem     = divFits ? divTrial[31:0] : divShifted[31:0];
    divQuot    = {accLo_q[30:0], divFits};
    quotSigned = negQuot_q ? -divQuot : divQuot;
    remSigned  = negRem_q ? -divRem : divRem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = MULT;
        end else if (start_div) begin
          state_d = (B == 32'd0) ? DONE : DIV;
        end
      end
      MULT:    if (lastIter) state_d = DONE;
      DIV:     if (lastIter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == MULT) || (state_q == DIV);
    done     = (state_q == DONE);
    div_zero = (state_q == DONE) && divZero_q;
    HI_out   = hi_q;
    LO_out   = lo_q;
  end

  // Operands are captured only in IDLE; HI/LO load only on the final iteration.
  always_comb begin
    count_d   = count_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    accQm1_d  = accQm1_q;
    operand_d = operand_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          count_d   = 6'd0;
          accHi_d   = 32'd0;
          accLo_d   = B;
          accQm1_d  = 1'b0;
          operand_d = A;
          divZero_d = 1'b0;
        end else if (start_div) begin
          count_d   = 6'd0;
          divZero_d = (B == 32'd0);
          if (B != 32'd0) begin
            accHi_d   = 32'd0;
            accLo_d   = absA;
            accQm1_d  = 1'b0;
            operand_d = absB;
            negQuot_d = A[31] ^ B[31];
            negRem_d  = A[31];
          end
        end
      end
      MULT: begin
        count_d  = count_q + 6'd1;
        accHi_d  = multHi;
        accLo_d  = multLo;
        accQm1_d = multQm1;
        if (lastIter) begin
          hi_d = multHi;
          lo_d = multLo;
        end
      end
      DIV: begin
        count_d = count_q + 6'd1;
        accHi_d = divRem;
        accLo_d = divQuot;
        if (lastIter) begin
          hi_d = remSigned;
          lo_d = quotSigned;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 6'd0;
      accHi_q   <= 32'd0;
      accLo_q   <= 32'd0;
      accQm1_q  <= 1'b0;
      operand_q <= 32'd0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      count_q   <= count_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      accQm1_q  <= accQm1_d;
      operand_q <= operand_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule
